// File: rtl/dnn_mlp_seq.sv
// Time-multiplexed 2-layer MLP (out = W2*relu(W1*x [+b1]) [+b2]) on one shared signed MAC.
// Optional bias ports and accumulator preload are enabled by defining DNN_BIAS_EN.
module dnn_mlp_seq #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_HID = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned X_W   = 7,
  parameter int unsigned W_W   = 5,
`ifdef DNN_BIAS_EN
  localparam int unsigned BE   = 1,
`else
  localparam int unsigned BE   = 0,
`endif
  localparam int unsigned S1_W = X_W + W_W + $clog2(N_IN) + BE,
  localparam int unsigned O_W  = S1_W + W_W + $clog2(N_HID) + BE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN*X_W-1:0]          x_flat,
  input  logic [N_IN*N_HID*W_W-1:0]    w1_flat,
  input  logic [N_HID*N_OUT*W_W-1:0]   w2_flat,
`ifdef DNN_BIAS_EN
  input  logic [N_HID*W_W-1:0]         b1_flat,
  input  logic [N_OUT*W_W-1:0]         b2_flat,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT*O_W-1:0]         out_flat,
  output logic                         busy
);

  localparam int unsigned IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int unsigned HW    = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int unsigned OCW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned ACC_W = O_W;
  localparam int unsigned P_W   = S1_W + W_W;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]  i_cnt;
  logic [HW-1:0]  h_cnt;
  logic [OCW-1:0] o_cnt;

  logic signed [X_W-1:0]   x_q   [N_IN];
  logic signed [S1_W-1:0]  hid_q [N_HID];
  logic signed [ACC_W-1:0] acc_q;

  logic                    last_i, last_h, last_o, accept;
  int unsigned             w1_base, w2_base, out_base;
  logic signed [S1_W-1:0]  mac_a;
  logic signed [W_W-1:0]   mac_b;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] sum, acc_pre;

  assign last_i = (i_cnt == IW'(N_IN - 1));
  assign last_h = (h_cnt == HW'(N_HID - 1));
  assign last_o = (o_cnt == OCW'(N_OUT - 1));
  assign accept = (state_q == IDLE) && in_valid;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)          state_d = L1;
      L1:      if (last_i && last_h)  state_d = L2;
      L2:      if (last_h && last_o)  state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Shared MAC operand select: layer 1 uses x/w1, layer 2 uses hid/w2
  always_comb begin
    w1_base  = (32'(h_cnt) * N_IN + 32'(i_cnt)) * W_W;
    w2_base  = (32'(o_cnt) * N_HID + 32'(h_cnt)) * W_W;
    out_base = 32'(o_cnt) * O_W;
    mac_a    = '0;
    mac_b    = '0;
    if (state_q == L2) begin
      mac_a = hid_q[h_cnt];
      mac_b = $signed(w2_flat[w2_base +: W_W]);
    end else begin
      mac_a = S1_W'(x_q[i_cnt]);
      mac_b = $signed(w1_flat[w1_base +: W_W]);
    end
    prod = P_W'(mac_a) * P_W'(mac_b);
    sum  = acc_q + ACC_W'(prod);
  end

  // Accumulator start value for the neuron that begins next
  always_comb begin
    acc_pre = '0;
`ifdef DNN_BIAS_EN
    unique case (state_q)
      IDLE: acc_pre = ACC_W'($signed(b1_flat[W_W-1:0]));
      L1:   acc_pre = last_h ? ACC_W'($signed(b2_flat[W_W-1:0]))
                             : ACC_W'($signed(b1_flat[(32'(h_cnt) + 1) * W_W +: W_W]));
      L2:   acc_pre = last_o ? '0
                             : ACC_W'($signed(b2_flat[(32'(o_cnt) + 1) * W_W +: W_W]));
      default: acc_pre = '0;
    endcase
`endif
  end

  // Datapath: input capture, accumulation, ReLU write-back, result write
  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt    <= '0;
      h_cnt    <= '0;
      o_cnt    <= '0;
      acc_q    <= '0;
      out_flat <= '0;
      for (int i = 0; i < int'(N_IN); i++)  x_q[i]   <= '0;
      for (int h = 0; h < int'(N_HID); h++) hid_q[h] <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          for (int i = 0; i < int'(N_IN); i++) x_q[i] <= $signed(x_flat[i*X_W +: X_W]);
          acc_q <= acc_pre;
          i_cnt <= '0;
          h_cnt <= '0;
          o_cnt <= '0;
        end
        L1: if (last_i) begin
          hid_q[h_cnt] <= sum[ACC_W-1] ? '0 : sum[S1_W-1:0];
          acc_q        <= acc_pre;
          i_cnt        <= '0;
          h_cnt        <= last_h ? '0 : h_cnt + HW'(1);
        end else begin
          acc_q <= sum;
          i_cnt <= i_cnt + IW'(1);
        end
        L2: if (last_h) begin
          out_flat[out_base +: O_W] <= sum;
          acc_q <= acc_pre;
          h_cnt <= '0;
          o_cnt <= last_o ? '0 : o_cnt + OCW'(1);
        end else begin
          acc_q <= sum;
          h_cnt <= h_cnt + HW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
